rfir_coeff_loader: RTL and testbench

RFIR_COEFF_LOADER -- requirements
Module: rfir_coeff_loader

---
 rtl/rfir_coeff_loader.sv | 138 +++++++++++++
 tb/tb_rfir_coeff_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rfir_coeff_loader.sv
// rtl/rfir_coeff_loader.sv - streams 24/48/72 RFIR coefficients into the coefficient RAM and enables the filter
// Optional checksum word after the last coefficient: define RFIR_COEFF_CHECKSUM_EN.
module rfir_coeff_loader #(
  parameter int MAX_TAPS = 72,
  parameter int ADDR_W   = 7
) (
  input  logic               clk_r,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         tap_sel,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [15:0] s_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  addr_out,
  output logic [15:0]        coeff_out,
  output logic               en_rfir,
  output logic [1:0]         mode_rfir,
  output logic               busy,
  output logic               done,
  output logic               err
);

`ifdef RFIR_COEFF_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, ERROR = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, ERROR = 2'd3} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [ADDR_W-1:0] last_idx;
  logic [1:0]        tap_lat;
  logic [ADDR_W-1:0] last_sel;
  logic              tap_ok;
`ifdef RFIR_COEFF_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  // Tap modes beyond what the RAM was built for are rejected like tap_sel=00.
  always_comb begin
    last_sel = ADDR_W'(24 * int'(tap_sel) - 1);
    tap_ok   = (tap_sel != 2'b00) && (24 * int'(tap_sel) <= MAX_TAPS);
  end

  always_ff @(posedge clk_r) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      last_idx  <= '0;
      tap_lat   <= 2'b00;
      s_ready   <= 1'b0;
      wr_en     <= 1'b0;
      addr_out  <= '0;
      coeff_out <= '0;
      en_rfir   <= 1'b0;
      mode_rfir <= 2'b00;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef RFIR_COEFF_CHECKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, ERROR: begin
          if (start) begin
            if (tap_ok) begin
              tap_lat  <= tap_sel;
              last_idx <= last_sel;
              cnt      <= '0;
              done     <= 1'b0;
              err      <= 1'b0;
              en_rfir  <= 1'b0;
              busy     <= 1'b1;
              s_ready  <= 1'b1;
`ifdef RFIR_COEFF_CHECKSUM_EN
              checksum <= '0;
`endif
              state    <= LOAD;
            end else begin
              err     <= 1'b1;
              en_rfir <= 1'b0;
              done    <= 1'b0;
              busy    <= 1'b0;
              s_ready <= 1'b0;
              state   <= ERROR;
            end
          end
        end
        LOAD: begin
          if (s_valid && s_ready) begin
            wr_en     <= 1'b1;
            addr_out  <= cnt;
            coeff_out <= s_data;
            cnt       <= cnt + 1'b1;
`ifdef RFIR_COEFF_CHECKSUM_EN
            checksum  <= checksum + s_data;
            // s_ready stays high so the checksum word can follow immediately.
            if (cnt == last_idx) state <= CHECK;
`else
            if (cnt == last_idx) begin
              s_ready   <= 1'b0;
              done      <= 1'b1;
              en_rfir   <= 1'b1;
              mode_rfir <= tap_lat;
              busy      <= 1'b0;
              state     <= IDLE;
            end
`endif
          end
        end
`ifdef RFIR_COEFF_CHECKSUM_EN
        CHECK: begin
          if (s_valid && s_ready) begin
            s_ready <= 1'b0;
            busy    <= 1'b0;
            if (s_data == checksum) begin
              done      <= 1'b1;
              en_rfir   <= 1'b1;
              mode_rfir <= tap_lat;
              state     <= IDLE;
            end else begin
              err     <= 1'b1;
              en_rfir <= 1'b0;
              done    <= 1'b0;
              state   <= ERROR;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rfir_coeff_loader.sv
// tb/tb_rfir_coeff_loader.sv - randomized self-checking bench for rfir_coeff_loader
// Honours RFIR_COEFF_CHECKSUM_EN by appending the expected checksum word to each load.
module tb_rfir_coeff_loader;

  logic               clk_r = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [1:0]         tap_sel = 2'b00;
  logic               s_valid = 1'b0;
  logic               s_ready;
  logic signed [15:0] s_data = '0;
  logic               wr_en;
  logic [6:0]         addr_out;
  logic [15:0]        coeff_out;
  logic               en_rfir;
  logic [1:0]         mode_rfir;
  logic               busy;
  logic               done;
  logic               err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] coeffs[72];
  logic [6:0]  got_addr[$];
  logic [15:0] got_data[$];
  int          bad_gap = 0;
  logic        last_sv = 1'b0;

  rfir_coeff_loader dut (
    .clk_r(clk_r), .reset(reset), .start(start), .tap_sel(tap_sel),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .wr_en(wr_en), .addr_out(addr_out), .coeff_out(coeff_out),
    .en_rfir(en_rfir), .mode_rfir(mode_rfir),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk_r = ~clk_r;

  // Collect every RAM write; a write must follow a cycle where s_valid was high.
  always @(negedge clk_r) begin
    if (wr_en) begin
      got_addr.push_back(addr_out);
      got_data.push_back(coeff_out);
      if (!last_sv) bad_gap++;
    end
    last_sv = s_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, " s_ready"}, s_ready, 0);
    check_eq({tag, " wr_en"}, wr_en, 0);
    check_eq({tag, " addr_out"}, addr_out, 0);
    check_eq({tag, " coeff_out"}, coeff_out, 0);
    check_eq({tag, " en_rfir"}, en_rfir, 0);
    check_eq({tag, " mode_rfir"}, mode_rfir, 0);
    check_eq({tag, " busy"}, busy, 0);
    check_eq({tag, " done"}, done, 0);
    check_eq({tag, " err"}, err, 0);
  endtask

  // vmode: 0 back-to-back, 1 toggling, 2 random. abort_at/poke_at < 0 disables.
  task automatic run_load(input string tag, input logic [1:0] ts, input int vmode,
                          input int abort_at, input int poke_at, input bit bad_cks);
    int n;
    int sent;
    int budget;
    bit v;
    bit rdy;
    bit poked;
    logic [15:0] sum;
    n = 24 * int'(ts);
    sent = 0; budget = 0; poked = 0; sum = '0;
    got_addr.delete(); got_data.delete(); bad_gap = 0;
    start = 1'b1; tap_sel = ts;
    @(posedge clk_r); #1;
    start = 1'b0;
    check_eq({tag, " busy after start"}, busy, 1);
    while (sent < n && budget < 2000) begin
      case (vmode)
        0: v = 1'b1;
        1: v = budget[0];
        default: v = 1'($urandom_range(0, 1));
      endcase
      budget++;
      s_valid = v;
      s_data = coeffs[sent];
      if (sent == poke_at && !poked) begin
        start = 1'b1;
        tap_sel = (ts == 2'b01) ? 2'b11 : 2'b01;
        poked = 1'b1;
      end
      rdy = s_ready;
      @(posedge clk_r); #1;
      start = 1'b0; tap_sel = ts;
      if (v && rdy) begin
        sum = sum + coeffs[sent];
        sent++;
      end
      if (abort_at >= 0 && sent == abort_at) begin
        s_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk_r); #1;
        reset = 1'b0;
        check_all_zero({tag, " abort"});
        return;
      end
    end
    check_eq({tag, " load timeout"}, budget < 2000, 1);
    s_valid = 1'b0;
`ifdef RFIR_COEFF_CHECKSUM_EN
    check_eq({tag, " s_ready in CHECK"}, s_ready, 1);
    s_valid = 1'b1;
    s_data = bad_cks ? sum + 16'd1 : sum;
    @(posedge clk_r); #1;
    s_valid = 1'b0;
`else
    if (bad_cks) sum = sum;
`endif
    @(posedge clk_r); #1;
    check_eq({tag, " s_ready after"}, s_ready, 0);
    check_eq({tag, " busy after"}, busy, 0);
    check_eq({tag, " write count"}, got_addr.size(), n);
    check_eq({tag, " write while s_valid low"}, bad_gap, 0);
    for (int i = 0; i < n && i < got_addr.size(); i++) begin
      check_eq({tag, " addr"}, got_addr[i], i);
      check_eq({tag, " coeff"}, got_data[i], coeffs[i]);
    end
`ifdef RFIR_COEFF_CHECKSUM_EN
    if (bad_cks) begin
      check_eq({tag, " err"}, err, 1);
      check_eq({tag, " en_rfir"}, en_rfir, 0);
      check_eq({tag, " done"}, done, 0);
      return;
    end
`endif
    check_eq({tag, " done"}, done, 1);
    check_eq({tag, " en_rfir"}, en_rfir, 1);
    check_eq({tag, " mode_rfir"}, mode_rfir, ts);
    check_eq({tag, " err"}, err, 0);
    repeat (3) @(posedge clk_r);
    #1;
    check_eq({tag, " en_rfir hold"}, en_rfir, 1);
    check_eq({tag, " mode_rfir hold"}, mode_rfir, ts);
  endtask

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk_r);
    #1;
    reset = 1'b0;
    check_all_zero("reset");

    for (int i = 0; i < 72; i++) coeffs[i] = 16'(i + 1);
    run_load("t24", 2'b01, 0, -1, -1, 0);

    for (int i = 0; i < 72; i++) coeffs[i] = 16'($urandom);
    run_load("t48 toggle", 2'b10, 1, -1, -1, 0);

    start = 1'b1; tap_sel = 2'b00;
    @(posedge clk_r); #1;
    start = 1'b0;
    check_eq("invalid err", err, 1);
    check_eq("invalid s_ready", s_ready, 0);
    check_eq("invalid busy", busy, 0);
    check_eq("invalid en_rfir", en_rfir, 0);
    got_addr.delete(); got_data.delete();
    s_valid = 1'b1;
    repeat (4) @(posedge clk_r);
    #1;
    s_valid = 1'b0;
    check_eq("invalid no writes", got_addr.size(), 0);
    for (int i = 0; i < 72; i++) coeffs[i] = 16'($urandom);
    run_load("t72 after err", 2'b11, 0, -1, -1, 0);

    run_load("abort", 2'b01, 0, 10, -1, 0);
    run_load("after abort", 2'b01, 2, -1, -1, 0);

    run_load("start during load", 2'b01, 0, -1, 5, 0);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 72; i++) coeffs[i] = 16'($urandom);
      run_load("random", 2'($urandom_range(1, 3)), 2, -1, -1, 0);
    end

`ifdef RFIR_COEFF_CHECKSUM_EN
    for (int i = 0; i < 72; i++) coeffs[i] = 16'h1000;
    run_load("cks good", 2'b01, 0, -1, -1, 0);
    run_load("cks bad", 2'b01, 0, -1, -1, 1);
    run_load("cks recover", 2'b01, 1, -1, -1, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
